// File: rtl/alu_pkg.sv
// Shared constants for the ALU with registered result.
//   ALU_WIDTH : default operand, result and register width
//   ALUC_*    : operation-select encodings driven on Aluc
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [1:0] ALUC_ADD = 2'b00;
    localparam logic [1:0] ALUC_SUB = 2'b01;
    localparam logic [1:0] ALUC_AND = 2'b10;
    localparam logic [1:0] ALUC_OR  = 2'b11;

endpackage

// File: rtl/d_ffec32.sv
// Enabled register bank with asynchronous active-low clear.
// Ports:
//   Clk  in  : rising-edge clock
//   Clrn in  : async active-low clear, overrides En
//   En   in  : load enable
//   D    in  : [WIDTH] data in
//   Q    out : [WIDTH] registered data
//   Qn   out : [WIDTH] bitwise complement of Q (valid during clear)
module d_ffec32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            Q <= '0;
        end else if (En) begin
            Q <= D;
        end
    end

    assign Qn = ~Q;

endmodule

// File: rtl/alu_d_ffec32.sv
// Combinational ALU (add/sub/and/or) with zero flag, feeding an enabled,
// async-clear result register.
// Ports:
//   Clk  in  : rising-edge clock
//   Clrn in  : async active-low clear of the result register
//   X, Y in  : [WIDTH] operands
//   Aluc in  : [2] operation select (see alu_pkg)
//   En   in  : result register load enable
//   R    out : [WIDTH] combinational result
//   Z    out : 1 iff R == 0
//   Q    out : [WIDTH] registered result
//   Qn   out : [WIDTH] ~Q
// Optional build macro ALU_FLAGS_EN adds:
//   C, V   out : carry (NOT borrow on subtract) and signed overflow; 0 for logic ops
//   Cq, Vq out : registered C and V, loaded and cleared with Q
module alu_d_ffec32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       Aluc,
    input  logic             En,
    output logic [WIDTH-1:0] R,
`ifdef ALU_FLAGS_EN
    output logic             C,
    output logic             V,
    output logic             Cq,
    output logic             Vq,
`endif
    output logic             Z,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    always_comb begin
        R = '0;
        case (Aluc)
            ALUC_ADD: R = X + Y;
            ALUC_SUB: R = X - Y;
            ALUC_AND: R = X & Y;
            ALUC_OR:  R = X | Y;
            default:  R = '0;
        endcase
    end

    assign Z = ~|R;

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH+1:0] bank_d;
    logic [WIDTH+1:0] bank_q;
    logic [WIDTH+1:0] bank_qn;

    // Subtract is formed as X + ~Y + 1 so the carry-out is the inverted borrow.
    always_comb begin
        add_ext = {1'b0, X} + {1'b0, Y};
        sub_ext = {1'b0, X} + {1'b0, ~Y} + {{WIDTH{1'b0}}, 1'b1};
        C = 1'b0;
        V = 1'b0;
        case (Aluc)
            ALUC_ADD: begin
                C = add_ext[WIDTH];
                V = (X[WIDTH-1] == Y[WIDTH-1]) && (add_ext[WIDTH-1] != X[WIDTH-1]);
            end
            ALUC_SUB: begin
                C = sub_ext[WIDTH];
                V = (X[WIDTH-1] != Y[WIDTH-1]) && (sub_ext[WIDTH-1] != X[WIDTH-1]);
            end
            default: begin
                C = 1'b0;
                V = 1'b0;
            end
        endcase
    end

    // Flags ride in the same bank as the result so they load/clear together.
    assign bank_d = {V, C, R};

    d_ffec32 #(.WIDTH(WIDTH + 2)) u_reg (
        .Clk  (Clk),
        .Clrn (Clrn),
        .En   (En),
        .D    (bank_d),
        .Q    (bank_q),
        .Qn   (bank_qn)
    );

    assign Q  = bank_q[WIDTH-1:0];
    assign Qn = bank_qn[WIDTH-1:0];
    assign Cq = bank_q[WIDTH];
    assign Vq = bank_q[WIDTH+1];
`else
    d_ffec32 #(.WIDTH(WIDTH)) u_reg (
        .Clk  (Clk),
        .Clrn (Clrn),
        .En   (En),
        .D    (R),
        .Q    (Q),
        .Qn   (Qn)
    );
`endif

endmodule

// File: tb/tb_alu_d_ffec32.sv
module tb_alu_d_ffec32;

    localparam int W = 32;

    logic         Clk;
    logic         Clrn;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic [1:0]   Aluc;
    logic         En;
    logic [W-1:0] R;
    logic         Z;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;
`ifdef ALU_FLAGS_EN
    logic         C;
    logic         V;
    logic         Cq;
    logic         Vq;
`endif

    int checks = 0;
    int errors = 0;

    alu_d_ffec32 #(.WIDTH(W)) dut (
        .Clk  (Clk),
        .Clrn (Clrn),
        .X    (X),
        .Y    (Y),
        .Aluc (Aluc),
        .En   (En),
        .R    (R),
`ifdef ALU_FLAGS_EN
        .C    (C),
        .V    (V),
        .Cq   (Cq),
        .Vq   (Vq),
`endif
        .Z    (Z),
        .Q    (Q),
        .Qn   (Qn)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [1:0]   aluc;
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vecs[11];

    initial begin
        //            x             y             aluc   r             z     c     v
        vecs[0]  = '{32'h0000000C, 32'h0000000A, 2'b10, 32'h00000008, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000000C, 32'h0000000A, 2'b11, 32'h0000000E, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 2'b00, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'h00000005, 32'h00000005, 2'b01, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{32'h00000000, 32'h00000001, 2'b01, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{32'h7FFFFFFF, 32'h00000001, 2'b00, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{32'h00000000, 32'h0000FFFF, 2'b10, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h00000000, 32'h00000000, 2'b11, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h00000001, 2'b01, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{32'h00000123, 32'h00000543, 2'b00, 32'h00000666, 1'b0, 1'b0, 1'b0};

        Clrn = 1'b1;
        En   = 1'b0;
        X    = '0;
        Y    = '0;
        Aluc = 2'b00;

        // Reset asserted between edges: register clears with no clock.
        #2 Clrn = 1'b0;
        #1;
        check("reset_q", Q, 32'h00000000);
        check("reset_qn", Qn, 32'hFFFFFFFF);

        // Datapath keeps working during reset; clear overrides En at an edge.
        X = 32'hC; Y = 32'hA; Aluc = 2'b10; En = 1'b1;
        #1;
        check("rst_comb_r", R, 32'h00000008);
        check("rst_comb_z", {31'b0, Z}, 32'h0);
        @(posedge Clk); #1;
        check("rst_override_q", Q, 32'h00000000);
        check("rst_override_qn", Qn, 32'hFFFFFFFF);
`ifdef ALU_FLAGS_EN
        check("rst_cq", {31'b0, Cq}, 32'h0);
        check("rst_vq", {31'b0, Vq}, 32'h0);
`endif

        @(negedge Clk);
        Clrn = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge Clk);
            X = vecs[i].x; Y = vecs[i].y; Aluc = vecs[i].aluc; En = 1'b1;
            #1;
            check($sformatf("vec%0d_r", i), R, vecs[i].r);
            check($sformatf("vec%0d_z", i), {31'b0, Z}, {31'b0, vecs[i].z});
`ifdef ALU_FLAGS_EN
            check($sformatf("vec%0d_c", i), {31'b0, C}, {31'b0, vecs[i].c});
            check($sformatf("vec%0d_v", i), {31'b0, V}, {31'b0, vecs[i].v});
`endif
            @(posedge Clk); #1;
            check($sformatf("vec%0d_q", i), Q, vecs[i].r);
            check($sformatf("vec%0d_qn", i), Qn, ~vecs[i].r);
`ifdef ALU_FLAGS_EN
            check($sformatf("vec%0d_cq", i), {31'b0, Cq}, {31'b0, vecs[i].c});
            check($sformatf("vec%0d_vq", i), {31'b0, Vq}, {31'b0, vecs[i].v});
`endif
        end

        // Hold: Q was last loaded with 0x666; disable and move R to 1.
        @(negedge Clk);
        En = 1'b0; X = 32'h1; Y = 32'h0; Aluc = 2'b00;
        #1;
        check("hold_r", R, 32'h00000001);
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            check($sformatf("hold_q%0d", k), Q, 32'h00000666);
        end

        // Reset mid-operation.
        @(negedge Clk);
        En = 1'b1;
        @(posedge Clk); #1;
        check("midop_load", Q, 32'h00000001);
        #2 Clrn = 1'b0;
        #1;
        check("midop_clr_q", Q, 32'h00000000);
        check("midop_clr_qn", Qn, 32'hFFFFFFFF);
        @(posedge Clk); #1;
        check("midop_held_clr", Q, 32'h00000000);
        @(negedge Clk);
        Clrn = 1'b1;
        X = 32'h55; Y = 32'h0F; Aluc = 2'b10;
        #1;
        check("midop_r", R, 32'h00000005);
        check("midop_still_clr", Q, 32'h00000000);
        @(posedge Clk); #1;
        check("midop_first_load", Q, 32'h00000005);
        check("midop_first_qn", Qn, 32'hFFFFFFFA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
